// File: rtl/cpu_pkg.sv
// Shared decode definitions: RV32I opcodes, format codes, decode-stage FSM states
// and the internal decoded-field bundle.
package cpu_pkg;

  localparam int unsigned ILEN   = 32;
  localparam int unsigned RIDX_W = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_SYS = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  typedef struct packed {
    logic [RIDX_W-1:0] rs1;
    logic [RIDX_W-1:0] rs2;
    logic [RIDX_W-1:0] rd;
    fmt_e              fmt;
    logic              reg_write;
    logic              is_load;
    logic              illegal;
  } dec_t;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle around the decode stage.
// master: the surrounding pipeline; slave: the decode stage itself.
interface decode_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned REG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [REG_W-1:0] out_rs1;
  logic [REG_W-1:0] out_rs2;
  logic [REG_W-1:0] out_rd;
  logic [XLEN-1:0]  out_imm;
  logic             out_reg_write;
  logic             out_is_load;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [XLEN-1:0]  out_pc;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_rs1, out_rs2, out_rd, out_imm,
           out_reg_write, out_is_load, out_fmt, out_illegal, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_rs1, out_rs2, out_rd, out_imm,
           out_reg_write, out_is_load, out_fmt, out_illegal, out_pc
  );
endinterface

// File: rtl/imm_gen.sv
// Combinational immediate generator: assembles the RV32I immediate for the given
// format and sign-extends it from instr[31] to XLEN.
module imm_gen
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm_c
);

  logic [31:0] imm32_c;

  always_comb begin
    imm32_c = '0;
    case (fmt)
      FMT_I, FMT_SYS: imm32_c = {{20{instr[31]}}, instr[31:20]};
      FMT_S:          imm32_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:          imm32_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                 instr[11:8], 1'b0};
      FMT_J:          imm32_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                 instr[30:21], 1'b0};
      FMT_U:          imm32_c = {instr[31:12], 12'b0};
      default:        imm32_c = '0;
    endcase
  end

  assign imm_c = XLEN'($signed(imm32_c));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: one-entry registered output buffer with valid/ready on both
// sides, synchronous flush and an optional one-cycle load-use interlock.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned REG_W          = 5,
  parameter int unsigned LOAD_USE_STALL = 1
) (
  input logic           clk,
  input logic           rst_n,
  input logic           flush,
  decode_stage_if.slave bus
);

  state_e              state_q, state_d;
  dec_t                dec_c;
  logic [31:0]         instr_c;
  logic [XLEN-1:0]     imm_c;
  logic                dep_c, stall_hit_c, in_ready_c, accept_c, out_fire_c;
  logic                ld_valid_q;
  logic [RIDX_W-1:0]   ld_rd_q;

  logic                out_valid_q;
  logic [REG_W-1:0]    rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0]     imm_q, pc_q;
  logic                reg_write_q, is_load_q, illegal_q;
  logic [2:0]          fmt_q;

  assign instr_c = bus.in_instr;

  // Field decode; unused index fields stay zero so they never match the load tracker.
  always_comb begin
    dec_c         = '0;
    dec_c.fmt     = FMT_ILL;
    dec_c.illegal = 1'b1;
    case (instr_c[6:0])
      OP_R: begin
        dec_c.fmt       = FMT_R;
        dec_c.illegal   = 1'b0;
        dec_c.rs1       = instr_c[19:15];
        dec_c.rs2       = instr_c[24:20];
        dec_c.rd        = instr_c[11:7];
        dec_c.reg_write = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        dec_c.fmt       = FMT_I;
        dec_c.illegal   = 1'b0;
        dec_c.rs1       = instr_c[19:15];
        dec_c.rd        = instr_c[11:7];
        dec_c.reg_write = 1'b1;
        dec_c.is_load   = (instr_c[6:0] == OP_LOAD);
      end
      OP_STORE, OP_BRANCH: begin
        dec_c.fmt     = (instr_c[6:0] == OP_STORE) ? FMT_S : FMT_B;
        dec_c.illegal = 1'b0;
        dec_c.rs1     = instr_c[19:15];
        dec_c.rs2     = instr_c[24:20];
      end
      OP_LUI, OP_AUIPC, OP_JAL: begin
        dec_c.fmt       = (instr_c[6:0] == OP_JAL) ? FMT_J : FMT_U;
        dec_c.illegal   = 1'b0;
        dec_c.rd        = instr_c[11:7];
        dec_c.reg_write = 1'b1;
      end
      OP_SYSTEM: begin
        dec_c.fmt     = FMT_SYS;
        dec_c.illegal = 1'b0;
        dec_c.rs1     = instr_c[19:15];
        dec_c.rd      = instr_c[11:7];
      end
      default: ;
    endcase
    if (dec_c.rd == '0) dec_c.reg_write = 1'b0;
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (instr_c),
    .fmt   (dec_c.fmt),
    .imm_c (imm_c)
  );

  // Interlock only fires when the output slot is free this cycle, so a held bundle is never dropped.
  assign dep_c       = (dec_c.rs1 == ld_rd_q) || (dec_c.rs2 == ld_rd_q);
  assign stall_hit_c = (LOAD_USE_STALL != 0) && bus.in_valid && ld_valid_q && dep_c &&
                       (!out_valid_q || bus.out_ready) && (state_q != ST_STALL) && !flush;
  assign in_ready_c  = (!out_valid_q || bus.out_ready) && (state_q != ST_STALL) &&
                       !stall_hit_c && !flush;
  assign accept_c    = bus.in_valid && in_ready_c;
  assign out_fire_c  = out_valid_q && bus.out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (stall_hit_c)   state_d = ST_STALL;
        else if (accept_c) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (stall_hit_c)     state_d = ST_STALL;
        else if (accept_c)   state_d = ST_FULL;
        else if (out_fire_c) state_d = ST_EMPTY;
      end
      ST_STALL: state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (flush) state_d = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d == ST_FULL);
    end
  end

  // Output bundle only changes on accept, so it holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      reg_write_q <= 1'b0;
      is_load_q   <= 1'b0;
      illegal_q   <= 1'b0;
      fmt_q       <= '0;
    end else if (accept_c) begin
      rs1_q       <= REG_W'(dec_c.rs1);
      rs2_q       <= REG_W'(dec_c.rs2);
      rd_q        <= REG_W'(dec_c.rd);
      imm_q       <= imm_c;
      pc_q        <= bus.in_pc;
      reg_write_q <= dec_c.reg_write;
      is_load_q   <= dec_c.is_load;
      illegal_q   <= dec_c.illegal;
      fmt_q       <= dec_c.fmt;
    end
  end

  // Tracks the most recent accepted load; cleared by a bubble, a flush or the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_valid_q <= 1'b0;
      ld_rd_q    <= '0;
    end else if (flush || stall_hit_c) begin
      ld_valid_q <= 1'b0;
    end else if (accept_c) begin
      ld_valid_q <= dec_c.is_load && (dec_c.rd != '0);
      ld_rd_q    <= dec_c.rd;
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_rs1       = rs1_q;
  assign bus.out_rs2       = rs2_q;
  assign bus.out_rd        = rd_q;
  assign bus.out_imm       = imm_q;
  assign bus.out_reg_write = reg_write_q;
  assign bus.out_is_load   = is_load_q;
  assign bus.out_fmt       = fmt_q;
  assign bus.out_illegal   = illegal_q;
  assign bus.out_pc        = pc_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode table plus backpressure, load-use,
// flush and reset sequences on an interlocked and a non-interlocked instance.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32), .REG_W(5)) b1 ();
  decode_stage_if #(.XLEN(32), .REG_W(5)) b0 ();

  decode_stage #(.XLEN(32), .REG_W(5), .LOAD_USE_STALL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b1)
  );
  decode_stage #(.XLEN(32), .REG_W(5), .LOAD_USE_STALL(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b0)
  );

  localparam logic [31:0] ADDI = 32'hFFF08293;  // addi x5,x1,-1
  localparam logic [31:0] LUI  = 32'h123451B7;  // lui x3,0x12345
  localparam logic [31:0] LW6  = 32'h00012303;  // lw x6,0(x2)
  localparam logic [31:0] ADD7 = 32'h001303B3;  // add x7,x6,x1

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        wr, ld, ill;
    logic [2:0]  fmt;
  } vec_t;

  vec_t vt[12];
  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic offer(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic ordy);
    b1.in_valid = v; b1.in_instr = instr; b1.in_pc = pc; b1.out_ready = ordy;
    b0.in_valid = v; b0.in_instr = instr; b0.in_pc = pc; b0.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st1, st0, gap1, gap0;
    //         instr          rs1   rs2   rd    imm            wr    ld    ill   fmt
    vt[0]  = '{32'hFFF08293, 5'd1, 5'd0, 5'd5, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 3'd1};
    vt[1]  = '{32'h123451B7, 5'd0, 5'd0, 5'd3, 32'h12345000, 1'b1, 1'b0, 1'b0, 3'd4};
    vt[2]  = '{32'h001303B3, 5'd6, 5'd1, 5'd7, 32'h00000000, 1'b1, 1'b0, 1'b0, 3'd0};
    vt[3]  = '{32'hFE512E23, 5'd2, 5'd5, 5'd0, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 3'd2};
    vt[4]  = '{32'hFE208CE3, 5'd1, 5'd2, 5'd0, 32'hFFFFFFF8, 1'b0, 1'b0, 1'b0, 3'd3};
    vt[5]  = '{32'hFFDFF06F, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 3'd5};
    vt[6]  = '{32'h001000EF, 5'd0, 5'd0, 5'd1, 32'h00000800, 1'b1, 1'b0, 1'b0, 3'd5};
    vt[7]  = '{32'h00012303, 5'd2, 5'd0, 5'd6, 32'h00000000, 1'b1, 1'b1, 1'b0, 3'd1};
    vt[8]  = '{32'h12345FFF, 5'd0, 5'd0, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b1, 3'd7};
    vt[9]  = '{32'hFFFFF517, 5'd0, 5'd0, 5'd10, 32'hFFFFF000, 1'b1, 1'b0, 1'b0, 3'd4};
    vt[10] = '{32'h004280E7, 5'd5, 5'd0, 5'd1, 32'h00000004, 1'b1, 1'b0, 1'b0, 3'd1};
    vt[11] = '{32'h00208033, 5'd1, 5'd2, 5'd0, 32'h00000000, 1'b0, 1'b0, 1'b0, 3'd0};

    rst_n = 1'b0;
    flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0, 1'b1);
    #12;
    chk("rst.out_valid", b1.out_valid, 0);
    chk("rst.out_rd", b1.out_rd, 0);
    chk("rst.out_imm", b1.out_imm, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("rst.in_ready", b1.in_ready, 1);

    // Decode table, one instruction per cycle with downstream always ready.
    for (int i = 0; i < 12; i++) begin
      offer(1'b1, vt[i].instr, 32'h1000 + 32'(i * 4), 1'b1);
      #1 chk($sformatf("v%0d.in_ready", i), b1.in_ready, 1);
      tick();
      chk($sformatf("v%0d.valid", i), b1.out_valid, 1);
      chk($sformatf("v%0d.rs1", i), b1.out_rs1, vt[i].rs1);
      chk($sformatf("v%0d.rs2", i), b1.out_rs2, vt[i].rs2);
      chk($sformatf("v%0d.rd", i), b1.out_rd, vt[i].rd);
      chk($sformatf("v%0d.imm", i), b1.out_imm, vt[i].imm);
      chk($sformatf("v%0d.reg_write", i), b1.out_reg_write, vt[i].wr);
      chk($sformatf("v%0d.is_load", i), b1.out_is_load, vt[i].ld);
      chk($sformatf("v%0d.illegal", i), b1.out_illegal, vt[i].ill);
      chk($sformatf("v%0d.fmt", i), b1.out_fmt, vt[i].fmt);
      chk($sformatf("v%0d.pc", i), b1.out_pc, 32'h1000 + 32'(i * 4));
    end
    offer(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    chk("drain.valid", b1.out_valid, 0);

    // Backpressure: bundle held for three cycles, then released.
    offer(1'b1, ADDI, 32'h2000, 1'b0);
    #1 chk("bp.accept_ready", b1.in_ready, 1);
    tick();
    offer(1'b1, LUI, 32'h2004, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d.in_ready", k), b1.in_ready, 0);
      chk($sformatf("bp%0d.valid", k), b1.out_valid, 1);
      chk($sformatf("bp%0d.rd", k), b1.out_rd, 5);
      chk($sformatf("bp%0d.imm", k), b1.out_imm, 32'hFFFFFFFF);
      chk($sformatf("bp%0d.pc", k), b1.out_pc, 32'h2000);
      tick();
    end
    offer(1'b1, LUI, 32'h2004, 1'b1);
    #1 chk("bp.release_ready", b1.in_ready, 1);
    tick();
    chk("bp.next_rd", b1.out_rd, 3);
    chk("bp.next_pc", b1.out_pc, 32'h2004);
    offer(1'b0, 32'h0, 32'h0, 1'b1);
    tick();

    // Load-use: lw x6 then add x7,x6,x1 on both instances.
    st1 = 0; st0 = 0; gap1 = -1; gap0 = -1;
    offer(1'b1, LW6, 32'h3000, 1'b1);
    tick();
    offer(1'b1, ADD7, 32'h3004, 1'b1);
    for (int c = 0; c < 6; c++) begin
      #1;
      if (c == 0) chk("lu.hit_ready", b1.in_ready, 0);
      if (!b1.out_valid && !b1.in_ready) st1++;
      if (!b0.out_valid && !b0.in_ready) st0++;
      if (gap1 < 0 && b1.out_valid && b1.out_rd == 5'd7) gap1 = c;
      if (gap0 < 0 && b0.out_valid && b0.out_rd == 5'd7) gap0 = c;
      tick();
    end
    offer(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    tick();
    chk("lu.stall_cycles", 32'(st1), 1);
    chk("lu.stall_cycles_off", 32'(st0), 0);
    chk("lu.add_delay", 32'(gap1), 3);
    chk("lu.add_delay_off", 32'(gap0), 1);

    // A non-dependent instruction between load and use clears the tracker.
    offer(1'b1, LW6, 32'h4000, 1'b1);
    tick();
    offer(1'b1, ADDI, 32'h4004, 1'b1);
    #1 chk("lu.indep_ready", b1.in_ready, 1);
    tick();
    offer(1'b1, ADD7, 32'h4008, 1'b1);
    #1 chk("lu.cleared_ready", b1.in_ready, 1);
    tick();
    chk("lu.cleared_rd", b1.out_rd, 7);
    offer(1'b0, 32'h0, 32'h0, 1'b1);
    tick();

    // Flush with a held bundle and a pending offer.
    offer(1'b1, ADDI, 32'h5000, 1'b0);
    tick();
    flush = 1'b1;
    offer(1'b1, LUI, 32'h5004, 1'b1);
    #1 chk("fl.in_ready", b1.in_ready, 0);
    tick();
    flush = 1'b0;
    offer(1'b0, 32'h0, 32'h0, 1'b1);
    #1 chk("fl.valid", b1.out_valid, 0);
    tick();
    chk("fl.nothing_accepted", b1.out_valid, 0);

    // Flush clears the load tracker.
    offer(1'b1, LW6, 32'h5100, 1'b1);
    tick();
    flush = 1'b1;
    offer(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    flush = 1'b0;
    offer(1'b1, ADD7, 32'h5104, 1'b1);
    #1 chk("fl.tracker_ready", b1.in_ready, 1);
    tick();
    chk("fl.tracker_rd", b1.out_rd, 7);
    offer(1'b0, 32'h0, 32'h0, 1'b1);
    tick();

    // Asynchronous reset while a bundle is held.
    offer(1'b1, ADDI, 32'h6000, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", b1.out_valid, 0);
    chk("arst.imm", b1.out_imm, 0);
    chk("arst.rd", b1.out_rd, 0);
    offer(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    rst_n = 1'b1;
    offer(1'b1, LUI, 32'h6004, 1'b1);
    #1 chk("arst.in_ready", b1.in_ready, 1);
    tick();
    chk("arst.first_rd", b1.out_rd, 3);
    chk("arst.first_valid", b1.out_valid, 1);
    offer(1'b0, 32'h0, 32'h0, 1'b1);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the datapath width for the immediate and PC (32 or 64).
REQ-002 The block SHALL have parameter REG_W, default 5, meaning the register-index width.
REQ-003 The block SHALL have parameter LOAD_USE_STALL, default 1, meaning a load-use bubble is inserted when set and the check is bypassed when 0.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 Port clk  input  1  the single clock; all state updates on the rising edge.
REQ-006 Port rst_n  input  1  the asynchronous active-low reset.
REQ-007 Port flush  input  1  synchronous pipeline flush.
REQ-008 Port in_valid  input  1  an instruction is offered.
REQ-009 Port in_ready  output  1  the stage accepts the offered instruction this cycle.
REQ-010 Port in_instr  input  32  the raw RV32I instruction.
REQ-011 Port in_pc  input  XLEN  the PC of in_instr.
REQ-012 Port out_valid  output  1  the decoded bundle is valid.
REQ-013 Port out_ready  input  1  downstream accepts the bundle.
REQ-014 Ports out_rs1, out_rs2, out_rd  output  REG_W  source and destination indices.
REQ-015 Port out_imm  output  XLEN  the sign-extended immediate.
REQ-016 Port out_reg_write  output  1  the bundle writes rd.
REQ-017 Port out_is_load  output  1  the bundle is a load.
REQ-018 Port out_fmt  output  3  the format code (R/I/S/B/U/J/SYS).
REQ-019 Port out_illegal  output  1  the opcode is unsupported.
REQ-020 Port out_pc  output  XLEN  the registered in_pc.

Function
REQ-021 Decode SHALL be registered: a bundle accepted at edge N SHALL appear on the outputs after edge N (1-cycle latency).
REQ-022 Handshake: a transfer occurs when valid&&ready; out_* SHALL hold stable while out_valid&&!out_ready.
REQ-023 in_ready SHALL equal (!out_valid || out_ready) && state!=STALL && !stall_hit.
REQ-024 Opcodes: R 0110011, I-arith 0010011, load 0000011, store 0100011, branch 1100011, jal 1101111, jalr 1100111, lui 0110111, auipc 0010111, system 1110011; any other opcode SHALL set out_illegal=1, out_reg_write=0, and indices/imm to 0.
REQ-025 Immediates SHALL be sign-extended from instr[31] to XLEN: I={instr[31:20]}; S={instr[31:25],instr[11:7]}; B={instr[31],instr[7],instr[30:25],instr[11:8],0}; J={instr[31],instr[19:12],instr[20],instr[30:21],0}; U={instr[31:12],12'b0}; R imm is 0.
REQ-026 Unused source fields SHALL be driven to 0 (I/U/J rs2=0; U/J rs1=0); S/B rd SHALL be 0.
REQ-027 out_reg_write SHALL be 1 for R, I-arith, load, jal, jalr, lui and auipc, and SHALL be forced to 0 when rd==0.
REQ-028 The FSM SHALL have states EMPTY, FULL and STALL; EMPTY->FULL on accept; FULL->EMPTY on out transfer with no accept; FULL->FULL on simultaneous out transfer and accept.
REQ-029 Load-use: with LOAD_USE_STALL=1, when the held or just-emitted bundle is a load with rd!=0 and the offered instruction uses that rd as a live rs1/rs2, stall_hit SHALL force FSM->STALL for exactly one cycle with out_valid=0 and in_ready=0, then the instruction SHALL be accepted normally.
REQ-030 Load tracking SHALL clear after one bubble or after one non-dependent accept.
REQ-031 flush SHALL take priority over every event in its cycle: out_valid=0, FSM->EMPTY, load tracker cleared, and the offered instruction not accepted (in_ready=0).

Reset
REQ-032 While rst_n=0: FSM=EMPTY, out_valid=0, all out_* data=0, and the load tracker cleared.
REQ-033 Reset assertion mid-transfer SHALL drop the bundle with no partial output; in_ready SHALL be 1 on the first edge after deassertion.

Structure
REQ-034 Opcode constants, the fmt enum and the FSM state encoding SHALL live in shared package cpu_pkg.
REQ-035 One combinational sub-module, imm_gen, SHALL produce the immediate from in_instr and fmt.

Verification
REQ-036 Reset → out_valid=0 and in_ready=1; accept addi x5,x1,-1 (0xFFF08293) → next cycle rd=5, rs1=1, imm=0xFFFFFFFF, reg_write=1.
REQ-037 lui x3,0x12345 → imm=0x12345000, rs1=0, rs2=0.
REQ-038 out_ready=0 for 3 cycles with a bundle held → outputs stable, in_ready=0; release → transfer on the next edge.
REQ-039 lw x6,0(x2) followed by add x7,x6,x1 → exactly one out_valid=0 bubble between them; with LOAD_USE_STALL=0 → no bubble.
REQ-040 Opcode 0x7F → out_illegal=1, reg_write=0; flush asserted with in_valid=1 → out_valid=0 next cycle and nothing accepted.
